// File: rtl/i2c_target_m.sv
// I2C target exposing an 8x8-bit register file with a host read port and write-notify strobe.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample stability filter on SCL/SDA.
module i2c_target_m #(
    parameter logic [6:0] I2C_ADDR = 7'h50
) (
    input  logic       bbc_ck8,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [2:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_stb,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 8;
    localparam int unsigned CW   = 4;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      scl_sync, sda_sync;
    logic            scl_lvl, sda_lvl, scl_prev, sda_prev;
    logic [CW-1:0]   bit_cnt, cnt_nxt;
    logic [DW-1:0]   shreg, shreg_nxt;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic [DW-1:0]   regs [NREG];
    logic            sda_oe_nxt, busy_nxt, commit;

    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic scl_run, sda_run;

    // Accept a new level once three consecutive pin samples agree (two in sync[1] history, one in sync[0]).
    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            scl_lvl <= 1'b1;
            sda_lvl <= 1'b1;
            scl_run <= 1'b0;
            sda_run <= 1'b0;
        end else begin
            if (scl_sync[1] == scl_lvl) begin
                scl_run <= 1'b0;
            end else if (scl_run && (scl_sync[0] == scl_sync[1])) begin
                scl_lvl <= scl_sync[1];
                scl_run <= 1'b0;
            end else begin
                scl_run <= 1'b1;
            end
            if (sda_sync[1] == sda_lvl) begin
                sda_run <= 1'b0;
            end else if (sda_run && (sda_sync[0] == sda_sync[1])) begin
                sda_lvl <= sda_sync[1];
                sda_run <= 1'b0;
            end else begin
                sda_run <= 1'b1;
            end
        end
    end
`else
    assign scl_lvl = scl_sync[1];
    assign sda_lvl = sda_sync[1];
`endif

    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_lvl;
            sda_prev <= sda_lvl;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, byte_done, addr_hit;
    assign scl_rise  = scl_lvl & ~scl_prev;
    assign scl_fall  = ~scl_lvl & scl_prev;
    assign start_det = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_prev & ~sda_prev & sda_lvl;
    assign byte_done = scl_fall && (bit_cnt == CW'(8));
    assign addr_hit  = (shreg[7:1] == I2C_ADDR);

    always_ff @(posedge bbc_ck8) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Bus conditions take priority over any SCL edge in the same cycle.
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:     if (byte_done) state_nxt = addr_hit ? ADDR_ACK : IDLE;
                ADDR_ACK: if (scl_fall) state_nxt = shreg[0] ? RD_DATA : PTR;
                PTR:      if (byte_done) state_nxt = PTR_ACK;
                PTR_ACK:  if (scl_fall) state_nxt = WR_DATA;
                WR_DATA:  if (byte_done) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
                RD_DATA:  if (scl_fall && (bit_cnt == CW'(7))) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_lvl) state_nxt = WAIT;
                    else if (scl_fall)       state_nxt = RD_DATA;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        cnt_nxt    = bit_cnt;
        shreg_nxt  = shreg;
        ptr_nxt    = ptr;
        busy_nxt   = busy;
        sda_oe_nxt = sda_oe;
        commit     = 1'b0;
        if (start_det) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
        end else if (stop_det) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nxt = {shreg[6:0], sda_lvl};
                        cnt_nxt   = bit_cnt + CW'(1);
                    end else if (byte_done) begin
                        cnt_nxt = '0;
                        if (state == ADDR) begin
                            busy_nxt   = busy | addr_hit;
                            sda_oe_nxt = addr_hit;
                        end else if (state == PTR) begin
                            ptr_nxt    = shreg[AW-1:0];
                            sda_oe_nxt = 1'b1;
                        end else begin
                            commit     = 1'b1;
                            ptr_nxt    = ptr + AW'(1);
                            sda_oe_nxt = 1'b1;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK, RD_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt    = '0;
                        sda_oe_nxt = 1'b0;
                        if ((state == RD_ACK) || ((state == ADDR_ACK) && shreg[0])) begin
                            shreg_nxt  = regs[ptr];
                            sda_oe_nxt = ~regs[ptr][7];
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == CW'(7)) begin
                            cnt_nxt    = '0;
                            sda_oe_nxt = 1'b0;
                            ptr_nxt    = ptr + AW'(1);
                        end else begin
                            cnt_nxt    = bit_cnt + CW'(1);
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            sda_oe_nxt = ~shreg[6];
                        end
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            busy    <= 1'b0;
            sda_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            regs    <= '{default: '0};
        end else begin
            bit_cnt <= cnt_nxt;
            shreg   <= shreg_nxt;
            ptr     <= ptr_nxt;
            busy    <= busy_nxt;
            sda_oe  <= sda_oe_nxt;
            wr_stb  <= commit;
            if (commit) begin
                regs[ptr] <= shreg;
                wr_addr   <= ptr;
                wr_data   <= shreg;
            end
        end
    end

    assign host_rdata = regs[host_addr];

endmodule

// File: doc/i2c_target_m.md
# i2c_target_m

I2C target (responder) that answers a bit-banged I2C initiator, such as the SDA/SCL register bits on the CPU board. It exposes a small 8×8-bit register file over the bus. The block runs from the BBC 8 MHz clock and sits on the board's shared SCL/SDA pins. It gives on-board logic a parallel read port and a write-notify strobe.

## Interface
- `I2C_ADDR`, default 7'h50: 7-bit target address matched against the first byte after START.
- `bbc_ck8` in 1: sole clock; every flop is updated on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `scl` in 1: bus clock pin; input only, the target never stretches SCL.
- `sda_in` in 1: SDA pin value.
- `sda_oe` out 1: 1 pulls SDA low (open-drain); reset 0.
- `host_addr` in 3: combinational read select into the register file.
- `host_rdata` out 8: value of `reg[host_addr]`; reset 0x00.
- `wr_stb` out 1: one-cycle pulse when an I2C write commits a register; reset 0.
- `wr_addr` out 3: index of the committed register, valid while `wr_stb` is high; reset 0.
- `wr_data` out 8: committed value, valid while `wr_stb` is high; reset 0x00.
- `busy` out 1: high from an accepted address match until STOP; reset 0.

## Operation
Bus sampling:
- SCL and SDA pass through a 2-flop synchronizer; a third flop provides edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.

States and transitions:
- IDLE: START → ADDR.
- ADDR: shift in 8 bits MSB first, sampling on SCL rising edges.
  - On the 8th SCL fall, compare bits [7:1] with `I2C_ADDR`.
  - Match → ADDR_ACK and set `busy`.
  - Mismatch → IDLE, with `sda_oe` left at 0.
- ADDR_ACK: `sda_oe`=1 from the 8th SCL fall to the 9th SCL fall.
  - R/W=0 → PTR.
  - R/W=1 → RD_DATA, loading `reg[ptr]` into the shift register.
- PTR: receive one byte; ptr ← bits [2:0]; bits [7:3] are ignored. Then ACK → WR_DATA.
- WR_DATA: receive one byte.
  - On the 8th SCL fall: `reg[ptr]` ← byte, pulse `wr_stb`, ptr ← ptr+1.
  - Then ACK → WR_DATA again.
- RD_DATA: drive `sda_oe` = ~bit, MSB first. Each bit changes on an SCL fall; the first bit is driven at the ACK's closing SCL fall.
  - On the 8th SCL fall: release SDA and set ptr ← ptr+1.
  - Sample the initiator's ACK on the 9th SCL rise.
  - ACK (SDA low) → load `reg[ptr]` on the 9th SCL fall and continue in RD_DATA.
  - NACK → WAIT.
- WAIT: `sda_oe`=0; ignore SCL until START or STOP.

Pointer and bus events:
- ptr is 3 bits and wraps from 7 to 0. It is retained across transactions and reset to 0.
- START seen in any state (repeated start) → ADDR. ptr is kept and `sda_oe` is released.
- STOP seen in any state → IDLE, with `sda_oe`=0 and `busy`=0.
- If START/STOP and an SCL edge are detected in the same cycle, START/STOP wins.

Host port and reset:
- A host read of the register being committed in the same cycle returns the old value. The new value appears the following cycle.
- `reset` clears all registers to 0x00 and ptr to 0, and puts the state machine in IDLE from any state, including mid-byte. `sda_oe` is 0 in the cycle after `reset` is sampled.

## Timing
- Latency from pin to detected edge is 3 `bbc_ck8` cycles.
- `sda_oe` changes 1 cycle after a detected SCL fall. That is 4 cycles after the pin edge, which is within the SDA hold window because the initiator holds SCL low for ≥1.3 µs.
- SCL high and low phases must each be ≥4 cycles (500 ns). Both standard mode and fast mode (100/400 kHz) are supported.
- `wr_stb` fires once, 1 cycle after the 8th SCL fall of a data byte.
- `host_rdata` is combinational from `host_addr`.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN` defined:
  - After the synchronizer, each line passes a stability filter. A new level is accepted only after 3 consecutive identical samples.
  - Pin-to-event latency becomes 5 cycles and `sda_oe` latency becomes 6 cycles.
  - Pulses of 2 cycles or less are ignored.
- Undefined: no filter, with the latencies stated under Timing.

## Test plan
- Write with auto-increment: START, 0xA0, 0x02, 0x5A, 0xC3, STOP → target ACKs all 4 bytes, reg2=0x5A, reg3=0xC3, two `wr_stb` pulses (addr 2, then 3), `busy` back to 0 after STOP.
- Read via repeated start: START, 0xA0, 0x02, Sr, 0xA1, read with ACK then NACK, STOP → bytes 0x5A then 0xC3 are read, SDA is released after the NACK, ptr=4.
- Address mismatch: START, 0xA2, 0x00, STOP → `sda_oe` stays 0 throughout, no `wr_stb`, registers unchanged.
- Pointer wrap: write ptr 0x07 then data 0x11, 0x22 → reg7=0x11, reg0=0x22; ptr 0xFF behaves as 7.
- Reset mid-read: assert `reset` during bit 4 of a read byte while `sda_oe`=1 → next cycle `sda_oe`=0, `busy`=0, all `host_rdata` reads 0x00; the following well-formed transaction succeeds.
- Glitch filter: a 2-cycle low pulse on SDA while SCL is high → no START/STOP with `I2C_TARGET_GLITCH_FILTER_EN` defined; START then STOP detected without it.
